fp_addsub_unit: RTL and testbench

- Multi-cycle single-precision IEEE-754 add/subtract unit.
- Acts as the responder on the mul/div/FPU request/response interface. An initiator drives req_* and samples resp_valid, resp_fresult and resp_fflag.
- Accepts one operation at a time, performs alignment, addition, normalization and rounding, and returns the result and exception flags with fixed latency.

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/fp_addsub_unit_if.sv | 25 ++
 rtl/fp_lzc28.sv | 16 +
 rtl/fp_addsub_unit.sv | 215 +++++++++++++++++++++
 tb/tb_fp_addsub_unit.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared encodings for the single-precision add/subtract unit:
// op codes, rounding modes, flag positions and FSM states.
package fpu_pkg;

    localparam int MDF_OP_WIDTH = 4;
    localparam logic [MDF_OP_WIDTH-1:0] MDF_OP_FAD = 4'h4;
    localparam logic [MDF_OP_WIDTH-1:0] MDF_OP_FSB = 4'h5;

    // Codes 101-111 fall through to round-to-nearest-even.
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] DEFAULT_NAN = 32'hffc00000;
    localparam int          QNAN_BIT    = 22;

    // One state per cycle of the fixed acceptance-to-response latency.
    localparam int LAT = 4;
    typedef enum logic [$clog2(LAT)-1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM
    } state_t;

endpackage

// File: rtl/fp_addsub_unit_if.sv
// Request/response bus between an initiator and the add/subtract unit.
// The unit is the responder (slave modport).
interface fp_addsub_unit_if;

    logic                             req_valid;
    logic                             req_ready;
    logic [fpu_pkg::MDF_OP_WIDTH-1:0] req_op;
    logic [2:0]                       req_rm;
    logic [31:0]                      req_in_1;
    logic [31:0]                      req_in_2;
    logic                             resp_valid;
    logic [31:0]                      resp_fresult;
    logic [4:0]                       resp_fflag;

    modport master (
        output req_valid, req_op, req_rm, req_in_1, req_in_2,
        input  req_ready, resp_valid, resp_fresult, resp_fflag
    );

    modport slave (
        input  req_valid, req_op, req_rm, req_in_1, req_in_2,
        output req_ready, resp_valid, resp_fresult, resp_fflag
    );

endinterface

// File: rtl/fp_lzc28.sv
// Combinational leading-zero counter over a 28-bit value.
// Returns 28 for an all-zero input.
module fp_lzc28 (
    input  logic [27:0] value,
    output logic [4:0]  count
);

    // Scanning upward lets the most significant set bit win.
    always_comb begin
        count = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (value[i]) count = 5'(27 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_unit.sv
// Four-cycle IEEE-754 single-precision add/subtract responder:
// capture, align, add, normalize/round, then a one-cycle result strobe.
module fp_addsub_unit
    import fpu_pkg::*;
#(
    parameter int OP_W = MDF_OP_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    fp_addsub_unit_if.slave bus
);

    state_t state, state_nxt;

    logic [31:0]     x_q, y_q;
    logic [OP_W-1:0] op_q;
    logic [2:0]      rm_q;

    logic        sign_a_q, sub_q, spec_q, spec_nv_q, bad_op_q;
    logic [31:0] spec_res_q;
    logic [7:0]  exp_a_q;
    logic [26:0] ma_q, mb_q;

    logic [27:0] sum_q;
    logic        sign_q;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = ST_ALIGN;
            end
            ST_ALIGN: state_nxt = ST_ADD;
            ST_ADD:   state_nxt = ST_NORM;
            ST_NORM:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.req_valid) begin
            x_q  <= bus.req_in_1;
            y_q  <= bus.req_in_2;
            op_q <= bus.req_op;
            rm_q <= bus.req_rm;
        end
    end

    logic        sign_y_eff, x_nan, y_nan, x_snan, y_snan, x_inf, y_inf, swap, sticky;
    logic        spec, spec_nv;
    logic [31:0] spec_res;
    logic [7:0]  ex_eff, ey_eff, exp_diff;
    logic [23:0] sig_x, sig_y;
    logic [26:0] big_ext, small_ext, small_shifted;
    logic [4:0]  shamt;

    // Subnormals use exponent 1 with a clear hidden bit; shifts beyond 27 only feed sticky.
    always_comb begin
        sign_y_eff = y_q[31] ^ (op_q == MDF_OP_FSB);
        x_nan  = (&x_q[30:23]) & (|x_q[22:0]);
        y_nan  = (&y_q[30:23]) & (|y_q[22:0]);
        x_snan = x_nan & ~x_q[QNAN_BIT];
        y_snan = y_nan & ~y_q[QNAN_BIT];
        x_inf  = (&x_q[30:23]) & ~(|x_q[22:0]);
        y_inf  = (&y_q[30:23]) & ~(|y_q[22:0]);
        ex_eff = (x_q[30:23] == 8'd0) ? 8'd1 : x_q[30:23];
        ey_eff = (y_q[30:23] == 8'd0) ? 8'd1 : y_q[30:23];
        sig_x  = {|x_q[30:23], x_q[22:0]};
        sig_y  = {|y_q[30:23], y_q[22:0]};
        swap      = ey_eff > ex_eff;
        big_ext   = swap ? {sig_y, 3'b000} : {sig_x, 3'b000};
        small_ext = swap ? {sig_x, 3'b000} : {sig_y, 3'b000};
        exp_diff  = swap ? (ey_eff - ex_eff) : (ex_eff - ey_eff);
        shamt     = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
        small_shifted = small_ext >> shamt;
        sticky        = (small_shifted << shamt) != small_ext;

        spec     = 1'b1;
        spec_nv  = 1'b0;
        spec_res = 32'd0;
        if (x_nan) begin
            spec_res = x_q | (32'd1 << QNAN_BIT);
            spec_nv  = x_snan | y_snan;
        end else if (y_nan) begin
            spec_res = y_q | (32'd1 << QNAN_BIT);
            spec_nv  = y_snan;
        end else if (x_inf && y_inf && (x_q[31] != sign_y_eff)) begin
            spec_res = DEFAULT_NAN;
            spec_nv  = 1'b1;
        end else if (x_inf) begin
            spec_res = x_q;
        end else if (y_inf) begin
            spec_res = {sign_y_eff, 31'h7f800000};
        end else begin
            spec = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_ALIGN) begin
            sign_a_q   <= swap ? sign_y_eff : x_q[31];
            sub_q      <= x_q[31] ^ sign_y_eff;
            exp_a_q    <= swap ? ey_eff : ex_eff;
            ma_q       <= big_ext;
            mb_q       <= small_shifted | {26'd0, sticky};
            spec_q     <= spec;
            spec_nv_q  <= spec_nv;
            spec_res_q <= spec_res;
            bad_op_q   <= (op_q != MDF_OP_FAD) && (op_q != MDF_OP_FSB);
        end
    end

    logic [27:0] raw;
    logic        neg;

    always_comb begin
        raw = sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
        neg = sub_q & raw[27];
    end

    always_ff @(posedge clk) begin
        if (state == ST_ADD) begin
            sum_q  <= neg ? (~raw + 28'd1) : raw;
            sign_q <= sign_a_q ^ neg;
        end
    end

    logic [4:0]  lz;
    logic [8:0]  exp_in, sh_want, sh_max, sh, exp_n, exp_field;
    logic [26:0] mant;
    logic [31:0] pre, rnd, norm_res;
    logic [4:0]  norm_flg;
    logic        inexact, round_up, ovf, to_inf, zero_sign;

    fp_lzc28 u_lzc (
        .value (sum_q),
        .count (lz)
    );

    // Left shift stops at exponent 1, which yields a subnormal with a clear hidden bit.
    always_comb begin
        exp_in  = {1'b0, exp_a_q};
        sh_want = {4'd0, lz} - 9'd1;
        sh_max  = exp_in - 9'd1;
        sh      = (sh_want < sh_max) ? sh_want : sh_max;
        if (sum_q[27]) begin
            mant  = {sum_q[27:2], sum_q[1] | sum_q[0]};
            exp_n = exp_in + 9'd1;
        end else begin
            mant  = sum_q[26:0] << sh;
            exp_n = exp_in - sh;
        end
        exp_field = mant[26] ? exp_n : 9'd0;
        inexact   = |mant[2:0];
        case (rm_q)
            RM_RNE:  round_up = mant[2] & (mant[1] | mant[0] | mant[3]);
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = inexact & sign_q;
            RM_RUP:  round_up = inexact & ~sign_q;
            RM_RMM:  round_up = mant[2];
            default: round_up = mant[2] & (mant[1] | mant[0] | mant[3]);
        endcase
        pre = {exp_field, mant[25:3]};
        rnd = pre + {31'd0, round_up};
        ovf = rnd[31:23] >= 9'd255;
        case (rm_q)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sign_q;
            RM_RUP:  to_inf = ~sign_q;
            default: to_inf = 1'b1;
        endcase
        zero_sign = sub_q ? (rm_q == RM_RDN) : sign_a_q;

        norm_res = 32'd0;
        norm_flg = 5'd0;
        if (bad_op_q) begin
            norm_res = 32'd0;
        end else if (spec_q) begin
            norm_res          = spec_res_q;
            norm_flg[FLAG_NV] = spec_nv_q;
        end else if (sum_q == 28'd0) begin
            norm_res = {zero_sign, 31'd0};
        end else if (ovf) begin
            norm_res          = to_inf ? {sign_q, 31'h7f800000} : {sign_q, 31'h7f7fffff};
            norm_flg[FLAG_OF] = 1'b1;
            norm_flg[FLAG_NX] = 1'b1;
        end else begin
            norm_res          = {sign_q, rnd[30:0]};
            norm_flg[FLAG_NX] = inexact;
            norm_flg[FLAG_UF] = inexact & (rnd[30:23] == 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.resp_valid   <= 1'b0;
            bus.resp_fresult <= 32'd0;
            bus.resp_fflag   <= 5'd0;
        end else begin
            bus.resp_valid <= (state == ST_NORM);
            if (state == ST_NORM) begin
                bus.resp_fresult <= norm_res;
                bus.resp_fflag   <= norm_flg;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Self-checking bench for fp_addsub_unit: directed vectors, handshake corner
// sequences and random operands against an exact-arithmetic reference model.
module tb_fp_addsub_unit;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fp_addsub_unit_if bus ();

    fp_addsub_unit #(.OP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rm;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    vec_t vecs[17];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [2:0] rm,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [4:0] flg,
                                  output int lat, output int ready_hi);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rm    = rm;
        bus.req_in_1  = a;
        bus.req_in_2  = b;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat      = 1;
        ready_hi = 0;
        while (!bus.resp_valid && lat < 8) begin
            if (bus.req_ready) ready_hi++;
            @(negedge clk);
            lat++;
        end
        res = bus.resp_fresult;
        flg = bus.resp_fflag;
    endtask

    // Value of a finite float in units of 2^-149 (exact integer).
    function automatic logic [299:0] magnitude(input logic [31:0] f);
        logic [299:0] sig;
        int e;
        sig = 300'(f[22:0]);
        if (f[30:23] != 8'd0) sig[23] = 1'b1;
        e = (f[30:23] == 8'd0) ? 1 : int'(f[30:23]);
        return sig << (e - 1);
    endfunction

    task automatic ref_model(input logic [3:0] op, input logic [2:0] rm_in,
                             input logic [31:0] x, input logic [31:0] y,
                             output logic [31:0] res, output logic [4:0] flg);
        logic [2:0]   rm;
        logic         sy, s, xnan, ynan, xsn, ysn, xinf, yinf, up, inexact;
        logic [299:0] mx, my, m, rem, half, q;
        int p, k, bexp;
        rm  = (rm_in > 3'd4) ? 3'd0 : rm_in;
        res = 32'd0;
        flg = 5'd0;
        if (op != 4'h4 && op != 4'h5) return;
        sy   = y[31] ^ (op == 4'h5);
        xnan = (x[30:23] == 8'hff) && (x[22:0] != 0);
        ynan = (y[30:23] == 8'hff) && (y[22:0] != 0);
        xsn  = xnan && !x[22];
        ysn  = ynan && !y[22];
        xinf = (x[30:23] == 8'hff) && (x[22:0] == 0);
        yinf = (y[30:23] == 8'hff) && (y[22:0] == 0);
        if (xnan) begin
            res = x | 32'h00400000;
            flg = (xsn || ysn) ? 5'b10000 : 5'b00000;
        end else if (ynan) begin
            res = y | 32'h00400000;
            flg = ysn ? 5'b10000 : 5'b00000;
        end else if (xinf && yinf && (x[31] != sy)) begin
            res = 32'hffc00000;
            flg = 5'b10000;
        end else if (xinf) begin
            res = x;
        end else if (yinf) begin
            res = {sy, 31'h7f800000};
        end else begin
            mx = magnitude(x);
            my = magnitude(y);
            if (x[31] == sy) begin
                m = mx + my; s = x[31];
            end else if (mx >= my) begin
                m = mx - my; s = x[31];
            end else begin
                m = my - mx; s = sy;
            end
            if (m == 0) begin
                res = {(x[31] == sy) ? x[31] : (rm == 3'd2), 31'd0};
            end else begin
                p = 0;
                for (int i = 0; i < 300; i++) if (m[i]) p = i;
                if (p <= 23) begin
                    res = {s, m[30:0]};
                end else begin
                    k    = p - 23;
                    q    = m >> k;
                    rem  = m & ((300'd1 << k) - 300'd1);
                    half = 300'd1 << (k - 1);
                    inexact = (rem != 0);
                    case (rm)
                        3'd0:    up = (rem > half) || ((rem == half) && q[0]);
                        3'd1:    up = 1'b0;
                        3'd2:    up = inexact && s;
                        3'd3:    up = inexact && !s;
                        default: up = (rem >= half);
                    endcase
                    if (up) q = q + 300'd1;
                    if (q[24]) begin
                        q = q >> 1;
                        k = k + 1;
                    end
                    bexp = k + 1;
                    if (bexp >= 255) begin
                        if (rm == 3'd0 || rm == 3'd4 || (rm == 3'd2 && s) || (rm == 3'd3 && !s))
                            res = {s, 31'h7f800000};
                        else
                            res = {s, 31'h7f7fffff};
                        flg = 5'b00101;
                    end else begin
                        res = {s, 8'(bexp), q[22:0]};
                        flg = {4'b0000, inexact};
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_operand(input int base);
        logic [31:0] v;
        int e;
        v = $urandom;
        case ($urandom_range(0, 15))
            0: v[30:0]  = 31'h7f800000;
            1: v[30:23] = 8'hff;
            2: v[30:23] = 8'h00;
            3: v[30:0]  = 31'd0;
            4: v[30:0]  = 31'h7f7fffff;
            default: begin
                e = base + int'($urandom_range(0, 60)) - 30;
                if (e < 1)   e = 1;
                if (e > 254) e = 254;
                v[30:23] = 8'(e);
            end
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] res, exp_res, x, y;
        logic [4:0]  flg, exp_flg;
        logic [3:0]  op;
        logic [2:0]  rm;
        int lat, ready_hi, acc, last, gap_bad, nresp;

        vecs[0]  = '{4'h4, 3'd0, 32'h3f800000, 32'h40000000, 32'h40400000, 5'b00000};
        vecs[1]  = '{4'h5, 3'd0, 32'h3f800000, 32'h3f800000, 32'h00000000, 5'b00000};
        vecs[2]  = '{4'h5, 3'd2, 32'h3f800000, 32'h3f800000, 32'h80000000, 5'b00000};
        vecs[3]  = '{4'h4, 3'd0, 32'h7f7fffff, 32'h7f7fffff, 32'h7f800000, 5'b00101};
        vecs[4]  = '{4'h4, 3'd1, 32'h7f7fffff, 32'h7f7fffff, 32'h7f7fffff, 5'b00101};
        vecs[5]  = '{4'h4, 3'd0, 32'h7f800000, 32'hff800000, 32'hffc00000, 5'b10000};
        vecs[6]  = '{4'h4, 3'd0, 32'h7f800001, 32'h3f800000, 32'h7fc00001, 5'b10000};
        vecs[7]  = '{4'h4, 3'd0, 32'h3f800000, 32'h33800000, 32'h3f800000, 5'b00001};
        vecs[8]  = '{4'h4, 3'd3, 32'h3f800000, 32'h33800000, 32'h3f800001, 5'b00001};
        vecs[9]  = '{4'h4, 3'd0, 32'h00000001, 32'h00000001, 32'h00000002, 5'b00000};
        vecs[10] = '{4'h2, 3'd0, 32'h3f800000, 32'h3f800000, 32'h00000000, 5'b00000};
        vecs[11] = '{4'h4, 3'd4, 32'h3f800000, 32'h33800000, 32'h3f800001, 5'b00001};
        vecs[12] = '{4'h5, 3'd0, 32'h3f800000, 32'h40000000, 32'hbf800000, 5'b00000};
        vecs[13] = '{4'h4, 3'd2, 32'h7f7fffff, 32'h7f7fffff, 32'h7f7fffff, 5'b00101};
        vecs[14] = '{4'h4, 3'd0, 32'h3f800000, 32'hff800001, 32'hffc00001, 5'b10000};
        vecs[15] = '{4'h5, 3'd0, 32'h7f800000, 32'h7f800000, 32'hffc00000, 5'b10000};
        vecs[16] = '{4'h4, 3'd7, 32'h3f800000, 32'h33800000, 32'h3f800000, 5'b00001};

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'h0;
        bus.req_rm    = 3'd0;
        bus.req_in_1  = 32'd0;
        bus.req_in_2  = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_output("reset req_ready", 32'(bus.req_ready), 32'd1);
        check_output("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check_output("reset fresult", bus.resp_fresult, 32'd0);
        check_output("reset fflag", 32'(bus.resp_fflag), 32'd0);

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].rm, vecs[i].a, vecs[i].b, res, flg, lat, ready_hi);
            check_output($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
            check_output($sformatf("vec%0d busy ready", i), 32'(ready_hi), 32'd0);
            check_output($sformatf("vec%0d result", i), res, vecs[i].res);
            check_output($sformatf("vec%0d flags", i), 32'(flg), 32'(vecs[i].flg));
        end

        // req_valid held for 12 cycles: one acceptance every 4 cycles.
        @(negedge clk);
        bus.req_op    = 4'h4;
        bus.req_rm    = 3'd0;
        bus.req_in_1  = 32'h3f800000;
        bus.req_in_2  = 32'h40000000;
        bus.req_valid = 1'b1;
        acc = 0; last = -1; gap_bad = 0; nresp = 0;
        for (int c = 0; c < 18; c++) begin
            if (c == 12) bus.req_valid = 1'b0;
            if (bus.req_valid && bus.req_ready) begin
                acc++;
                if (acc > 1 && (c - last) != 4) gap_bad++;
                last = c;
            end
            if (bus.resp_valid) nresp++;
            @(negedge clk);
        end
        check_output("held valid acceptances", 32'(acc), 32'd3);
        check_output("held valid spacing", 32'(gap_bad), 32'd0);
        check_output("held valid last accept", 32'(last), 32'd8);
        check_output("held valid responses", 32'(nresp), 32'd3);

        // Reset while the op is in ADD drops it.
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("midop reset req_ready", 32'(bus.req_ready), 32'd1);
        check_output("midop reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check_output("midop reset fresult", bus.resp_fresult, 32'd0);
        check_output("midop reset fflag", 32'(bus.resp_fflag), 32'd0);
        nresp = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.resp_valid) nresp++;
            @(negedge clk);
        end
        check_output("midop reset no response", 32'(nresp), 32'd0);

        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15))
                                               : (($urandom_range(0, 1) == 0) ? 4'h4 : 4'h5);
            rm = 3'($urandom_range(0, 7));
            x  = rand_operand(int'($urandom_range(1, 254)));
            y  = rand_operand(int'(x[30:23]));
            case ($urandom_range(0, 7))
                0: y = (op == 4'h5) ? x : {~x[31], x[30:0]};
                1: y[30:23] = x[30:23];
                default: ;
            endcase
            ref_model(op, rm, x, y, exp_res, exp_flg);
            apply_stimulus(op, rm, x, y, res, flg, lat, ready_hi);
            check_output($sformatf("rand%0d op%0h rm%0d %h %h latency", i, op, rm, x, y), 32'(lat), 32'd4);
            check_output($sformatf("rand%0d op%0h rm%0d %h %h result", i, op, rm, x, y), res, exp_res);
            check_output($sformatf("rand%0d op%0h rm%0d %h %h flags", i, op, rm, x, y), 32'(flg), 32'(exp_flg));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
